// File: rtl/intirvx_operand_issue.sv
// Operand issue stage: register file with multi-port write-back, pending-bit
// scoreboard with write-back bypass, serialize blocking and an in-order issue FIFO.
module intirvx_operand_issue #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WB_PORTS = 2,
  parameter int DEPTH    = 2,
  parameter int CTRL_W   = 16,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [AW-1:0]            in_rs1_adr,
  input  logic [AW-1:0]            in_rs2_adr,
  input  logic                     in_rs1_en,
  input  logic                     in_rs2_en,
  input  logic [AW-1:0]            in_rd_adr,
  input  logic                     in_rd_en,
  input  logic                     in_serialize,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [XLEN-1:0]          out_imm,
  output logic [AW-1:0]            out_rd_adr,
  output logic                     out_rd_en,
  output logic                     out_serialize,
  output logic [XLEN-1:0]          out_rs1,
  output logic [XLEN-1:0]          out_rs2,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*AW-1:0]   wb_adr,
  input  logic [WB_PORTS*XLEN-1:0] wb_data,
  input  logic                     resolve,
  input  logic                     flush,
  output logic [CW-1:0]            fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [AW-1:0]     rd_adr;
    logic              rd_en;
    logic              serialize;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
  } entry_t;

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;
  logic             serial_block;

  entry_t           mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic wb_hit(input logic [AW-1:0]            adr,
                                  input logic [WB_PORTS-1:0]      v,
                                  input logic [WB_PORTS*AW-1:0]   a);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++)
      if (v[p] && a[p*AW +: AW] == adr && adr != '0) hit = 1'b1;
    return hit;
  endfunction

  // Later ports overwrite earlier ones, so the highest matching port wins.
  function automatic logic [XLEN-1:0] wb_value(input logic [AW-1:0]            adr,
                                               input logic [WB_PORTS-1:0]      v,
                                               input logic [WB_PORTS*AW-1:0]   a,
                                               input logic [WB_PORTS*XLEN-1:0] d);
    logic [XLEN-1:0] val;
    val = '0;
    for (int p = 0; p < WB_PORTS; p++)
      if (v[p] && a[p*AW +: AW] == adr) val = d[p*XLEN +: XLEN];
    return val;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic            rs1_hit, rs2_hit, rd_hit;
  logic            rs1_ok, rs2_ok, waw;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            accept, pop;
  entry_t          in_entry, head;
  logic [NREGS-1:0] wb_clr_vec, set_vec;

  assign rs1_hit = wb_hit(in_rs1_adr, wb_valid, wb_adr);
  assign rs2_hit = wb_hit(in_rs2_adr, wb_valid, wb_adr);
  assign rd_hit  = wb_hit(in_rd_adr,  wb_valid, wb_adr);

  assign rs1_ok = !in_rs1_en || in_rs1_adr == '0 || !pending[in_rs1_adr] || rs1_hit;
  assign rs2_ok = !in_rs2_en || in_rs2_adr == '0 || !pending[in_rs2_adr] || rs2_hit;
  assign waw    = in_rd_en && in_rd_adr != '0 && pending[in_rd_adr] && !rd_hit;

  assign rs1_val = (!in_rs1_en || in_rs1_adr == '0) ? '0 :
                   rs1_hit ? wb_value(in_rs1_adr, wb_valid, wb_adr, wb_data) : regs[in_rs1_adr];
  assign rs2_val = (!in_rs2_en || in_rs2_adr == '0) ? '0 :
                   rs2_hit ? wb_value(in_rs2_adr, wb_valid, wb_adr, wb_data) : regs[in_rs2_adr];

  assign in_ready = !flush && !serial_block && (count < CW'(DEPTH)) && rs1_ok && rs2_ok && !waw;
  assign accept   = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign fifo_count = count;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    in_entry           = '0;
    in_entry.pc        = in_pc;
    in_entry.ctrl      = in_ctrl;
    in_entry.imm       = in_imm;
    in_entry.rd_adr    = in_rd_adr;
    in_entry.rd_en     = in_rd_en;
    in_entry.serialize = in_serialize;
    in_entry.rs1       = rs1_val;
    in_entry.rs2       = rs2_val;
  end

  always_comb begin
    wb_clr_vec = '0;
    set_vec    = '0;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p]) wb_clr_vec[wb_adr[p*AW +: AW]] = 1'b1;
    if (accept && in_rd_en && in_rd_adr != '0) set_vec[in_rd_adr] = 1'b1;
  end

  // Write-back still commits during flush; x0 is never written.
  always_ff @(posedge clk) begin
    // NOTE: this storage is reset because x-registers and the out_* payload must read 0 after rst.
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && wb_adr[p*AW +: AW] != '0)
          regs[wb_adr[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
    if (rst || flush) pending <= '0;
    else              pending <= (pending & ~wb_clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst || flush)                serial_block <= 1'b0;
    else if (accept && in_serialize) serial_block <= 1'b1;
    else if (resolve)                serial_block <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  // Head entry is held in place until popped, so the payload is stable under backpressure.
  assign head          = mem[rd_ptr];
  assign out_pc        = head.pc;
  assign out_ctrl      = head.ctrl;
  assign out_imm       = head.imm;
  assign out_rd_adr    = head.rd_adr;
  assign out_rd_en     = head.rd_en;
  assign out_serialize = head.serialize;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;

endmodule

// File: tb/tb_intirvx_operand_issue.sv
// Self-checking bench for intirvx_operand_issue: directed scenarios followed by
// randomized traffic, all compared against a queue/array reference model.
module tb_intirvx_operand_issue;
  localparam int XLEN = 32, NREGS = 32, WB_PORTS = 2, DEPTH = 2, CTRL_W = 16;
  localparam int AW = 5, CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [AW-1:0] in_rs1_adr, in_rs2_adr, in_rd_adr;
  logic in_rs1_en, in_rs2_en, in_rd_en, in_serialize;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_imm, out_rs1, out_rs2;
  logic [CTRL_W-1:0] out_ctrl;
  logic [AW-1:0] out_rd_adr;
  logic out_rd_en, out_serialize;
  logic [WB_PORTS-1:0] wb_valid;
  logic [WB_PORTS*AW-1:0] wb_adr;
  logic [WB_PORTS*XLEN-1:0] wb_data;
  logic resolve, flush;
  logic [CW-1:0] fifo_count;

  intirvx_operand_issue #(.XLEN(XLEN), .NREGS(NREGS), .WB_PORTS(WB_PORTS),
                          .DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .in_imm(in_imm), .in_rs1_adr(in_rs1_adr), .in_rs2_adr(in_rs2_adr),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rd_adr(in_rd_adr),
    .in_rd_en(in_rd_en), .in_serialize(in_serialize),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .out_imm(out_imm), .out_rd_adr(out_rd_adr), .out_rd_en(out_rd_en),
    .out_serialize(out_serialize), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
    .resolve(resolve), .flush(flush), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, in-flight producers, and the
  // ordered list of instructions waiting for execute.
  typedef struct {
    logic [31:0] pc, imm, rs1, rs2;
    logic [15:0] ctrl;
    logic [4:0]  rd;
    logic        rd_en, ser;
  } ent_t;

  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  bit          m_serial;
  ent_t        m_q[$];

  function automatic bit m_hit(input logic [4:0] adr);
    bit h = 0;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] && wb_adr[p*AW +: AW] == adr && adr != 0) h = 1;
    return h;
  endfunction

  function automatic logic [31:0] m_wbval(input logic [4:0] adr);
    logic [31:0] v = 0;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] && wb_adr[p*AW +: AW] == adr) v = wb_data[p*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit m_src_ok(input bit en, input logic [4:0] adr);
    return !en || adr == 0 || !m_pend[adr] || m_hit(adr);
  endfunction

  function automatic logic [31:0] m_operand(input bit en, input logic [4:0] adr);
    if (!en || adr == 0) return 0;
    if (m_hit(adr)) return m_wbval(adr);
    return m_regs[adr];
  endfunction

  function automatic bit m_ready();
    if (flush || m_serial || m_q.size() >= DEPTH) return 0;
    if (!m_src_ok(in_rs1_en, in_rs1_adr) || !m_src_ok(in_rs2_en, in_rs2_adr)) return 0;
    if (in_rd_en && in_rd_adr != 0 && m_pend[in_rd_adr] && !m_hit(in_rd_adr)) return 0;
    return 1;
  endfunction

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic step();
    bit   rdy = 0, acc, pop;
    ent_t e;
    @(negedge clk);
    if (!rst) begin
      rdy = m_ready();
      check("in_ready", in_ready, rdy);
      check("out_valid", out_valid, m_q.size() != 0);
      check("fifo_count", fifo_count, m_q.size());
      if (m_q.size() != 0) begin
        check("out_pc", out_pc, m_q[0].pc);
        check("out_imm", out_imm, m_q[0].imm);
        check("out_rs1", out_rs1, m_q[0].rs1);
        check("out_rs2", out_rs2, m_q[0].rs2);
        check("out_meta", {out_ctrl, out_rd_adr, out_rd_en, out_serialize},
              {m_q[0].ctrl, m_q[0].rd, m_q[0].rd_en, m_q[0].ser});
      end
    end
    acc = !rst && in_valid && rdy;
    pop = m_q.size() != 0 && out_ready;
    e.pc = in_pc; e.imm = in_imm; e.ctrl = in_ctrl; e.rd = in_rd_adr;
    e.rd_en = in_rd_en; e.ser = in_serialize;
    e.rs1 = m_operand(in_rs1_en, in_rs1_adr);
    e.rs2 = m_operand(in_rs2_en, in_rs2_adr);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_serial = 0;
      m_q.delete();
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && wb_adr[p*AW +: AW] != 0)
          m_regs[wb_adr[p*AW +: AW]] = wb_data[p*XLEN +: XLEN];
      if (flush) begin
        m_q.delete();
        for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
        m_serial = 0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(e);
        for (int p = 0; p < WB_PORTS; p++)
          if (wb_valid[p]) m_pend[wb_adr[p*AW +: AW]] = 0;
        if (acc && in_rd_en && in_rd_adr != 0) m_pend[in_rd_adr] = 1;
        if (acc && in_serialize) m_serial = 1;
        else if (resolve)        m_serial = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_ctrl = 0; in_imm = 0;
    in_rs1_adr = 0; in_rs2_adr = 0; in_rd_adr = 0;
    in_rs1_en = 0; in_rs2_en = 0; in_rd_en = 0; in_serialize = 0;
    wb_valid = 0; wb_adr = 0; wb_data = 0; resolve = 0; flush = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input bit e1,
                       input logic [4:0] rs2, input bit e2, input logic [4:0] rd,
                       input bit rde, input logic [31:0] imm, input bit ser);
    in_valid = 1; in_pc = pc; in_ctrl = pc[15:0] ^ 16'h5a5a; in_imm = imm;
    in_rs1_adr = rs1; in_rs1_en = e1; in_rs2_adr = rs2; in_rs2_en = e2;
    in_rd_adr = rd; in_rd_en = rde; in_serialize = ser;
  endtask

  initial begin
    rst = 1; out_ready = 1;
    idle();
    step(); step();
    rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_payload", {out_pc, out_imm, out_rs1, out_rs2} == 0, 1);
    check("rst_meta", {out_ctrl, out_rd_adr, out_rd_en, out_serialize}, 0);

    // addi x5, x0, 7
    issue(32'h100, 5'd0, 1, 5'd0, 0, 5'd5, 1, 32'd7, 0);
    #1 check("addi_ready", in_ready, 1);
    step();
    idle();
    #1 check("addi_valid", out_valid, 1);
    check("addi_rs1", out_rs1, 0);
    check("addi_imm", out_imm, 7);
    step();

    // RAW on pending x5, released by a same-cycle write-back on port 1
    issue(32'h104, 5'd5, 1, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    #1 check("raw_stall", in_ready, 0);
    wb_valid = 2'b10; wb_adr = {5'd5, 5'd0}; wb_data = {32'h1234, 32'h0};
    #1 check("raw_bypass", in_ready, 1);
    step();
    idle();
    #1 check("raw_rs1", out_rs1, 32'h1234);
    step();
    issue(32'h108, 5'd5, 1, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    #1 check("x5_not_pending", in_ready, 1);
    step();
    idle();
    #1 check("x5_regfile", out_rs1, 32'h1234);
    step();

    // Same-address write on both ports: port 1 wins
    wb_valid = 2'b11; wb_adr = {5'd3, 5'd3}; wb_data = {32'hB, 32'hA};
    step();
    idle();
    issue(32'h10c, 5'd3, 1, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    step();
    idle();
    #1 check("wb_priority", out_rs1, 32'hB);
    step();

    // Backpressure fills the FIFO; entries drain in order
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      issue(32'h200 + 4 * k, 5'd0, 0, 5'd0, 0, 5'(10 + k), 1, 32'(k), 0);
      #1;
      if (k == 2) begin
        check("full_stall", in_ready, 0);
        check("full_count", fifo_count, 2);
      end else begin
        check("fill_ready", in_ready, 1);
      end
      step();
    end
    idle();
    out_ready = 1;
    #1 check("order0", out_pc, 32'h200);
    step();
    #1 check("order1", out_pc, 32'h204);
    step();
    #1 check("drained", out_valid, 0);

    // Serializing instruction blocks issue until resolve
    issue(32'h300, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0, 1);
    #1 check("ser_accept", in_ready, 1);
    step();
    issue(32'h304, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    #1 check("ser_block", in_ready, 0);
    step();
    resolve = 1;
    #1 check("ser_resolve_cycle", in_ready, 0);
    step();
    resolve = 0;
    #1 check("ser_release", in_ready, 1);
    step();
    idle();
    step(); step();

    // Flush with two queued entries and x7 pending
    out_ready = 0;
    issue(32'h400, 5'd0, 0, 5'd0, 0, 5'd7, 1, 32'd1, 0);
    step();
    issue(32'h404, 5'd0, 0, 5'd0, 0, 5'd8, 1, 32'd2, 0);
    step();
    issue(32'h408, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd3, 0);
    flush = 1;
    #1 check("flush_count_before", fifo_count, 2);
    check("flush_no_accept", in_ready, 0);
    step();
    flush = 0;
    #1 check("flush_out_valid", out_valid, 0);
    check("flush_count", fifo_count, 0);
    issue(32'h40c, 5'd7, 1, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    #1 check("flush_pend_clr", in_ready, 1);
    step();
    idle();
    out_ready = 1;
    step(); step();

    // Randomized traffic over a small register window to force hazards
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 249) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      resolve      = ($urandom_range(0, 7) == 0);
      in_valid     = ($urandom_range(0, 9) < 6);
      in_pc        = $urandom;
      in_ctrl      = 16'($urandom);
      in_imm       = $urandom;
      in_rs1_adr   = 5'($urandom_range(0, 7));
      in_rs2_adr   = 5'($urandom_range(0, 7));
      in_rd_adr    = 5'($urandom_range(0, 7));
      in_rs1_en    = 1'($urandom_range(0, 1));
      in_rs2_en    = 1'($urandom_range(0, 1));
      in_rd_en     = 1'($urandom_range(0, 1));
      in_serialize = ($urandom_range(0, 9) == 0);
      out_ready    = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_valid[p]            = ($urandom_range(0, 3) == 0);
        wb_adr[p*AW +: AW]     = 5'($urandom_range(0, 7));
        wb_data[p*XLEN +: XLEN] = $urandom;
      end
      step();
    end
    rst = 0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intirvx_operand_issue.md
INTIRVX_OPERAND_ISSUE -- requirements
Module: intirvx_operand_issue

Interface
REQ-001 Parameter XLEN, default 32, register and operand width.
REQ-002 Parameter NREGS, default 32, architectural register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 Parameter WB_PORTS, default 2, number of write-back ports (>=1).
REQ-004 Parameter DEPTH, default 2, issue FIFO entries (>=1).
REQ-005 Parameter CTRL_W, default 16, opaque decoded-control payload width.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid / in_ready  in / out  1 / 1  decode handshake
- in_pc  in  XLEN  instruction PC
- in_ctrl  in  CTRL_W  control payload
- in_imm  in  XLEN  pre-expanded immediate
- in_rs1_adr, in_rs2_adr  in  AW each  source addresses
- in_rs1_en, in_rs2_en  in  1 each  source used
- in_rd_adr  in  AW  destination
- in_rd_en  in  1  destination written
- in_serialize  in  1  branch/jump/return, blocks further issue
- out_valid / out_ready  out / in  1 / 1  execute handshake
- out_pc, out_ctrl, out_imm, out_rd_adr, out_rd_en, out_serialize  out  as inputs  registered copies
- out_rs1, out_rs2  out  XLEN each  operand values
- wb_valid  in  WB_PORTS  per-port write enable
- wb_adr  in  WB_PORTS*AW  packed, port p at [p*AW +: AW]
- wb_data  in  WB_PORTS*XLEN  packed, port p at [p*XLEN +: XLEN]
- resolve  in  1  serializing instruction completed
- flush  in  1  pipeline flush
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy

Function
REQ-008 Register file: NREGS x XLEN; x0 reads 0, writes to x0 ignored.
REQ-009 Write-back: each cycle every port with wb_valid set writes its register; same address on several ports -> highest port index wins.
REQ-010 Scoreboard: one pending bit per register; pending marks an in-flight producer.
REQ-011 Pending set on accept when in_rd_en=1 and in_rd_adr!=0; cleared on any wb_valid write to that address; set and clear on the same address in the same cycle -> set wins.
REQ-012 Source ready: en=0, or adr=0, or not pending, or pending with a same-cycle wb write to it (bypass).
REQ-013 Operand value: bypassed wb_data (highest matching port) when a write to that address is present this cycle, else register file contents; en=0 -> 0.
REQ-014 WAW stall: in_rd_en=1, in_rd_adr!=0 and rd pending with no same-cycle wb clear -> not ready.
REQ-015 in_ready = !flush & !serial_block & (count<DEPTH) & rs1 ready & rs2 ready & !WAW; combinational, no dependence on in_valid.
REQ-016 Accept = in_valid & in_ready; the entry is written into the FIFO with captured operands.
REQ-017 serial_block set on accepting in_serialize=1; cleared on resolve or flush; resolve and accept in the same cycle -> set wins.
REQ-018 FIFO: in-order, DEPTH entries, 1-cycle latency (accept at cycle N -> out_valid at N+1 when empty); pop on out_valid & out_ready; simultaneous push and pop when full is not permitted (in_ready=0 when full), when non-full count unchanged.
REQ-019 Output payload is stable while out_valid=1 and out_ready=0.
REQ-020 Flush: FIFO emptied, all pending bits and serial_block cleared next cycle; no accept in the flush cycle; wb writes in the flush cycle still commit to the register file.
REQ-021 Pointer wrap: read/write pointers wrap modulo DEPTH; count never exceeds DEPTH.

Reset
REQ-022 On rst: all registers 0, pending bits 0, serial_block 0, FIFO empty, out_valid 0, fifo_count 0, all out_* payload 0.
REQ-023 rst asserted mid-operation discards in-flight entries; rst has priority over flush, wb and accept.

Verification
REQ-024 Issue addi x5 (rs1=x0, rd=x5, imm=7), out_ready=1 -> out_valid next cycle, out_rs1=0, out_imm=7, x5 pending.
REQ-025 x5 pending; issue rs1=x5 -> in_ready=0; same cycle later wb port 1 writes x5=0x1234 -> in_ready=1, out_rs1=0x1234, x5 not pending.
REQ-026 wb ports 0 and 1 write x3=0xA and x3=0xB same cycle -> subsequent read of x3 returns 0xB.
REQ-027 DEPTH=2, out_ready=0, three back-to-back independent issues -> third stalls, fifo_count=2; release out_ready -> entries emerge in order.
REQ-028 Accept serialize=1 -> in_ready=0 until resolve; resolve -> next instruction accepted following cycle.
REQ-029 Two entries queued, x7 pending, flush -> next cycle out_valid=0, fifo_count=0, instruction reading x7 accepted immediately.
